// File: rtl/mux_pkg.sv
// Shared types and constants for the round-robin select arbiter.
package mux_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   // last resets to N - LAST_RST_OFS (= N-1) so the first search begins at index 0.
   localparam int LAST_RST_OFS = 1;

   function automatic int last_rst_idx(input int n);
      return n - LAST_RST_OFS;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Wrap-around priority search: first set req bit at or after start_i, modulo N.
module rr_pick #(
   parameter int N = 4,
   parameter int P = $clog2(N)
) (
   input  logic [N-1:0] req_i,
   input  logic [P-1:0] start_i,
   output logic         found_o,
   output logic [P-1:0] idx_o
);

   int c;

   always_comb begin
      found_o = 1'b0;
      idx_o   = '0;
      c       = 0;
      for (int k = 0; k < N; k++) begin
         // start_i is always < N, so one subtraction is enough to wrap.
         c = int'(start_i) + k;
         if (c >= N) c = c - N;
         if (!found_o && req_i[c]) begin
            found_o = 1'b1;
            idx_o   = P'(c);
         end
      end
   end

endmodule

// File: rtl/rr_sel_arbiter.sv
// Round-robin arbiter producing a registered N:1 mux select with a valid/ready
// handshake; grants are sticky until accepted and re-arbitrate without a bubble.
module rr_sel_arbiter
   import mux_pkg::*;
#(
   parameter int N = 4,
   parameter int P = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   output logic [P-1:0] S,
   output logic         gnt_valid,
   input  logic         gnt_ready,
   output logic [N-1:0] gnt_onehot
);

   localparam logic [P-1:0] LAST_RST = P'(last_rst_idx(N));
   localparam logic [P-1:0] IDX_MAX  = P'(N - 1);

   arb_state_e   state_q, state_d;
   logic [P-1:0] s_q, s_d;
   logic [P-1:0] last_q, last_d;
   logic         arm_q;
   logic [P-1:0] base, start, win;
   logic         found;

   // On a handshake last becomes S, so searching from S+1 equals searching from last+1.
   assign base  = (state_q == GRANT) ? s_q : last_q;
   assign start = (base == IDX_MAX) ? '0 : base + 1'b1;

   rr_pick #(.N(N), .P(P)) u_pick (
      .req_i   (req),
      .start_i (start),
      .found_o (found),
      .idx_o   (win)
   );

   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      last_d  = last_q;
      case (state_q)
         IDLE: begin
            // arm_q holds off the first grant to the second edge after reset release.
            if (arm_q && found) begin
               state_d = GRANT;
               s_d     = win;
            end
         end
         GRANT: begin
            if (gnt_ready) begin
               last_d = s_q;
               if (found) s_d = win;
               else       state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         s_q     <= '0;
         last_q  <= LAST_RST;
         arm_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         last_q  <= last_d;
         arm_q   <= 1'b1;
      end
   end

   assign S         = s_q;
   assign gnt_valid = (state_q == GRANT);

   always_comb begin
      gnt_onehot = '0;
      if (gnt_valid) gnt_onehot[s_q] = 1'b1;
   end

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Scoreboard bench for rr_sel_arbiter: N=4 instance against a cycle model,
// plus an N=5 instance for the non-power-of-two select range.
module tb_rr_sel_arbiter;

   localparam int N  = 4;
   localparam int N5 = 5;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req = '0;
   logic       ready = 1'b0;
   logic [1:0] s;
   logic       vld;
   logic [3:0] oh;

   logic [4:0] req5 = '0;
   logic       ready5 = 1'b0;
   logic [2:0] s5;
   logic       vld5;
   logic [4:0] oh5;

   always #5 clk = ~clk;

   rr_sel_arbiter #(.N(N)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
      .S          (s),
      .gnt_valid  (vld),
      .gnt_ready  (ready),
      .gnt_onehot (oh)
   );

   rr_sel_arbiter #(.N(N5)) dut5 (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req5),
      .S          (s5),
      .gnt_valid  (vld5),
      .gnt_ready  (ready5),
      .gnt_onehot (oh5)
   );

   typedef struct {
      logic       v;
      int         s;
      logic [3:0] oh;
   } exp_t;

   exp_t sbq[$];
   int   total = 0;
   int   bad = 0;

   logic m_v;
   int   m_s;
   int   m_last;
   logic m_arm;

   int seq30[5] = '{0, 1, 2, 3, 0};
   int seq32[4] = '{0, 3, 0, 3};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int pick(input logic [3:0] r, input int from);
      for (int k = 1; k <= N; k++)
         if (r[(from + k) % N]) return (from + k) % N;
      return -1;
   endfunction

   task automatic model_rst();
      m_v    = 1'b0;
      m_s    = 0;
      m_last = N - 1;
      m_arm  = 1'b0;
      sbq.delete();
   endtask

   // Drive one cycle, push the model's post-edge expectation, pop and compare after the edge.
   task automatic step(input logic [3:0] r, input logic rd);
      exp_t e;
      int   w;
      req   = r;
      ready = rd;
      if (!m_arm) m_arm = 1'b1;
      else if (!m_v) begin
         w = pick(r, m_last);
         if (w >= 0) begin
            m_v = 1'b1;
            m_s = w;
         end
      end else if (rd) begin
         m_last = m_s;
         w = pick(r, m_s);
         if (w >= 0) m_s = w;
         else        m_v = 1'b0;
      end
      e.v  = m_v;
      e.s  = m_s;
      e.oh = m_v ? 4'(1 << m_s) : 4'b0;
      sbq.push_back(e);
      @(posedge clk);
      #1;
      e = sbq.pop_front();
      chk("vld", 32'(vld), 32'(e.v));
      chk("onehot", 32'(oh), 32'(e.oh));
      if (e.v) chk("s", 32'(s), e.s);
   endtask

   task automatic do_reset();
      rst_n  = 1'b0;
      req    = '0;
      ready  = 1'b0;
      req5   = '0;
      ready5 = 1'b0;
      model_rst();
      @(posedge clk);
      #1;
      chk("rst_vld", 32'(vld), 0);
      chk("rst_s", 32'(s), 0);
      chk("rst_oh", 32'(oh), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Handshakes granted to others while a request stays asserted.
   int fw[N];
   int fw_max = 0;

   always @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (!rst_n || !req[i]) fw[i] = 0;
         else if (vld && ready) begin
            if (int'(s) == i) fw[i] = 0;
            else              fw[i] = fw[i] + 1;
         end
         if (fw[i] > fw_max) fw_max = fw[i];
         assert (fw[i] <= N) else $error("FAIL fair idx=%0d waited=%0d limit=%0d", i, fw[i], N);
      end
   end

   initial begin
      logic [3:0] r;

      do_reset();
      step(4'hF, 1'b1);
      chk("arm_delay", 32'(vld), 0);
      for (int k = 0; k < 5; k++) begin
         step(4'hF, 1'b1);
         chk("s_seq_all", 32'(s), seq30[k]);
         chk("v_seq_all", 32'(vld), 1);
      end

      do_reset();
      for (int k = 0; k < 5; k++) step(4'b0100, 1'b0);
      chk("sticky_s", 32'(s), 2);
      for (int k = 0; k < 2; k++) begin
         step(4'b0000, 1'b0);
         chk("sticky_hold_s", 32'(s), 2);
         chk("sticky_hold_v", 32'(vld), 1);
      end
      step(4'b0000, 1'b1);
      chk("drop_to_idle", 32'(vld), 0);

      do_reset();
      step(4'b1001, 1'b1);
      for (int k = 0; k < 4; k++) begin
         step(4'b1001, 1'b1);
         chk("wrap_s", 32'(s), seq32[k]);
      end

      do_reset();
      step(4'b0100, 1'b0);
      step(4'b0100, 1'b0);
      chk("pre_rst_s", 32'(s), 2);
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst_vld", 32'(vld), 0);
      chk("async_rst_s", 32'(s), 0);
      chk("async_rst_oh", 32'(oh), 0);
      model_rst();
      @(posedge clk);
      #1 rst_n = 1'b1;
      step(4'hF, 1'b1);
      step(4'hF, 1'b1);
      chk("post_rst_first", 32'(s), 0);

      do_reset();
      req5   = 5'b10000;
      ready5 = 1'b1;
      for (int k = 0; k < 8; k++) begin
         step(4'b0000, 1'b0);
         if (k == 0) chk("n5_arm", 32'(vld5), 0);
         else begin
            chk("n5_s", 32'(s5), 4);
            chk("n5_vld", 32'(vld5), 1);
            chk("n5_oh", 32'(oh5), 32'h10);
         end
      end

      do_reset();
      r = 4'b0101;
      for (int k = 0; k < 10000; k++) begin
         if ($urandom_range(0, 5) == 0) r[$urandom_range(0, 3)] ^= 1'b1;
         step(r, 1'($urandom_range(0, 1)));
      end
      chk("fair_bound", 32'(fw_max <= N), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rr_sel_arbiter.md
RR_SEL_ARBITER -- requirements
Module: rr_sel_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the number of requesters and the mux input count; legal range is N >= 2.
REQ-002 The block SHALL have parameter P, default $clog2(N), giving the select width.
REQ-003 Clocking SHALL be one clock with an asynchronous, active-low reset.
REQ-004 Port clk: input, 1 bit, rising-edge clock.
REQ-005 Port rst_n: input, 1 bit, asynchronous active-low reset.
REQ-006 Port req: input, N bits, one request bit per mux input index.
REQ-007 Port S: output, P bits, granted index that drives the downstream N:1 mux select.
REQ-008 Port gnt_valid: output, 1 bit, asserted when S holds a valid grant.
REQ-009 Port gnt_ready: input, 1 bit, consumer accepts the current grant.
REQ-010 Port gnt_onehot: output, N bits, one-hot decode of S, qualified by gnt_valid.

Function
REQ-011 The FSM SHALL have two states: IDLE (no grant) and GRANT (gnt_valid=1).
REQ-012 In IDLE, if any req bit is 1, the block SHALL register the winner into S and enter GRANT, so gnt_valid rises on the next edge (1-cycle latency).
REQ-013 The winner SHALL be the first set req bit searched from index (last+1) mod N upward, wrapping to 0 through last; last is the most recently accepted index.
REQ-014 A handshake SHALL occur on a cycle with gnt_valid=1 and gnt_ready=1; on that edge last SHALL load S.
REQ-015 On handshake, if any req bit is 1 in the same cycle, the block SHALL stay in GRANT and load the next winner, searched from (S+1) mod N, with no bubble cycle.
REQ-016 On handshake, if req is all zeros, the block SHALL go to IDLE and drop gnt_valid on the next edge.
REQ-017 In GRANT without a handshake, S and gnt_valid SHALL hold. Deasserting the granted req bit SHALL NOT revoke or change the grant (sticky grant).
REQ-018 A sole requester SHALL be re-granted back-to-back: search wraps to the same index.
REQ-019 S SHALL never take a value >= N, including for non-power-of-two N.
REQ-020 gnt_onehot SHALL equal (1 << S) when gnt_valid=1 and all zeros otherwise.
REQ-021 gnt_onehot SHALL be combinational from registered state only; no combinational path from req or gnt_ready to any output.
REQ-022 The fairness bound SHALL be: a continuously asserted request is granted within N handshakes.

Reset
REQ-023 While rst_n=0, state SHALL be IDLE, S=0, gnt_valid=0, gnt_onehot=0, and last=N-1, so that index 0 has first priority after reset.
REQ-024 Reset asserted mid-grant SHALL clear the outstanding grant immediately (asynchronous), without waiting for a handshake.
REQ-025 The first grant after rst_n deasserts SHALL occur no earlier than the second rising edge after release.

Structure
REQ-026 The FSM state typedef (IDLE, GRANT) SHALL live in shared package mux_pkg.
REQ-027 The reset value of last SHALL be a named constant in mux_pkg.
REQ-028 The wrap-around priority search SHALL be one combinational sub-module, rr_pick, with inputs req and start index and outputs found flag and index; rr_sel_arbiter SHALL instantiate it once.
REQ-029 All registers SHALL be in a single clocked process using the asynchronous active-low reset.

Verification
REQ-030 Scenario: N=4, reset, then req=4'b1111 with gnt_ready=1 held -> S sequence 0,1,2,3,0 on consecutive cycles, gnt_valid continuously 1 after the first grant.
REQ-031 Scenario: req=4'b0100, gnt_ready=0 for 5 cycles, then req dropped to 0 -> S=2 and gnt_valid=1 held throughout; after gnt_ready=1 for one cycle, gnt_valid=0 on the next edge.
REQ-032 Scenario: last=3, req=4'b1001, ready=1 -> grants 0,3,0,3 (wrap correctness).
REQ-033 Scenario: N=5, req=5'b10000 only, ready=1 -> S=4 on every cycle; S never 5..7; gnt_onehot=5'b10000.
REQ-034 Scenario: rst_n pulsed low while gnt_valid=1, S=2 -> outputs zero asynchronously; after release with req=4'b1111, first grant is S=0.
REQ-035 Scenario: random req/ready for 10k cycles -> an assertion checks the REQ-022 bound, and gnt_onehot matches S.
